// File: rtl/fanout_fork_pkg.sv
// Shared types and default sizes for the fanout eager-fork controller.
package fanout_fork_pkg;

  localparam int DEF_NUM_OUT = 7;
  localparam int DEF_DATA_W  = 16;

  typedef logic [DEF_NUM_OUT-1:0] mask_t;

  // EMPTY: no token held; HOLD: one token waiting for its consumers
  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/fanout_fork_ctrl_if.sv
// Producer/consumer handshake bundle for fanout_fork_ctrl.
// master: the environment (producer + consumers); slave: the controller.
interface fanout_fork_ctrl_if
  import fanout_fork_pkg::*;
#(
  parameter int NUM_OUT = DEF_NUM_OUT,
  parameter int DATA_W  = DEF_DATA_W
);

  logic               in_valid;
  logic [DATA_W-1:0]  in_data;
  logic               in_ready;
  logic [NUM_OUT-1:0] out_valid;
  logic [DATA_W-1:0]  out_data;
  logic [NUM_OUT-1:0] out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/fanout_done_tracker.sv
// Per-branch delivery tracking for one held token: which enabled branches
// have already taken it, which are still offered, and when all are done.
module fanout_done_tracker
  import fanout_fork_pkg::*;
#(
  parameter int NUM_OUT = DEF_NUM_OUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               full,
  input  logic               load,
  input  logic [NUM_OUT-1:0] mask,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [NUM_OUT-1:0] out_valid,
  output logic               all_acc
);

  logic [NUM_OUT-1:0] done_r;
  logic [NUM_OUT-1:0] fire_s;

  // Offer the token to enabled branches that have not yet taken it
  always_comb begin
    out_valid = {NUM_OUT{1'b0}};
    fire_s    = {NUM_OUT{1'b0}};
    all_acc   = 1'b0;
    if (full) begin
      out_valid = mask & ~done_r;
      fire_s    = out_valid & out_ready;
      all_acc   = &((done_r | fire_s) | ~mask);
    end else begin
      out_valid = {NUM_OUT{1'b0}};
      fire_s    = {NUM_OUT{1'b0}};
      all_acc   = 1'b0;
    end
  end

  // Remember deliveries; a fresh token or a retirement starts from zero
  always_ff @(posedge clk) begin
    if (reset) begin
      done_r <= {NUM_OUT{1'b0}};
    end else if (load || all_acc) begin
      done_r <= {NUM_OUT{1'b0}};
    end else if (full) begin
      done_r <= done_r | fire_s;
    end else begin
      done_r <= {NUM_OUT{1'b0}};
    end
  end

endmodule

// File: rtl/fanout_fork_ctrl.sv
// Sequential eager-fork controller: holds one producer token and broadcasts
// it to up to NUM_OUT consumers, releasing the producer only after every
// enabled branch has accepted it.
// Build option: FANOUT_FORK_PASSTHRU_EN lets a retiring token and a new
// capture share a cycle (combinational out_ready -> in_ready path).
module fanout_fork_ctrl
  import fanout_fork_pkg::*;
#(
  parameter int NUM_OUT = DEF_NUM_OUT,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_OUT-1:0] cfg_mask,
  fanout_fork_ctrl_if.slave  bus,
  output logic               busy
);

  state_e             state_r;
  logic [DATA_W-1:0]  data_r;
  logic [NUM_OUT-1:0] mask_r;
  logic               full_s;
  logic               in_ready_s;
  logic               load_s;
  logic               all_acc_s;
  logic [NUM_OUT-1:0] out_valid_s;

  assign full_s = (state_r == HOLD);

  // Producer may hand over a token when the buffer is (or is becoming) free
  always_comb begin
`ifdef FANOUT_FORK_PASSTHRU_EN
    in_ready_s = ~full_s | all_acc_s;
`else
    in_ready_s = ~full_s;
`endif
  end

  // A captured token with an empty mask is accepted and dropped
  assign load_s = bus.in_valid & in_ready_s & (|cfg_mask);

  fanout_done_tracker #(
    .NUM_OUT (NUM_OUT)
  ) u_tracker (
    .clk       (clk),
    .reset     (reset),
    .full      (full_s),
    .load      (load_s),
    .mask      (mask_r),
    .out_ready (bus.out_ready),
    .out_valid (out_valid_s),
    .all_acc   (all_acc_s)
  );

  // Buffer FSM: capture payload and routing, retire once all branches took it
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= EMPTY;
      data_r  <= {DATA_W{1'b0}};
      mask_r  <= {NUM_OUT{1'b0}};
    end else begin
      case (state_r)
        EMPTY: begin
          if (load_s) begin
            state_r <= HOLD;
            data_r  <= bus.in_data;
            mask_r  <= cfg_mask;
          end else begin
            state_r <= EMPTY;
          end
        end
        HOLD: begin
          if (load_s) begin
            state_r <= HOLD;
            data_r  <= bus.in_data;
            mask_r  <= cfg_mask;
          end else if (all_acc_s) begin
            state_r <= EMPTY;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r <= EMPTY;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = data_r;
  assign busy          = full_s;

endmodule

// File: tb/tb_fanout_fork_ctrl.sv
// Self-checking bench for fanout_fork_ctrl: a token-level reference model
// with per-branch delivery queues, directed scenarios with literal
// expectations, and a randomized traffic phase.
`timescale 1ns/1ps
module tb_fanout_fork_ctrl;
  import fanout_fork_pkg::*;

  localparam int N = DEF_NUM_OUT;
  localparam int W = DEF_DATA_W;
`ifdef FANOUT_FORK_PASSTHRU_EN
  localparam bit PASSTHRU = 1'b1;
`else
  localparam bit PASSTHRU = 1'b0;
`endif

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  mask_t cfg_mask;
  logic  busy;
  int    cyc = 0;

  fanout_fork_ctrl_if #(.NUM_OUT(N), .DATA_W(W)) bus ();

  fanout_fork_ctrl #(.NUM_OUT(N), .DATA_W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_mask (cfg_mask),
    .bus      (bus),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model (token level) ----------------
  bit           m_started = 1'b0;
  bit           m_full = 1'b0;
  logic [W-1:0] m_data = '0;
  mask_t        m_mask = '0;
  mask_t        m_got  = '0;
  logic [W-1:0] sb [N][$];

  task automatic model_cycle();
    mask_t exp_valid;
    int    waiting;
    bit    retire, rdy, take;
    exp_valid = '0;
    for (int i = 0; i < N; i++)
      if (m_full && m_mask[i] && !m_got[i]) exp_valid[i] = 1'b1;
    waiting = 0;
    for (int i = 0; i < N; i++)
      if (exp_valid[i] && !bus.out_ready[i]) waiting++;
    retire = m_full && (waiting == 0);
    rdy    = !m_full || (PASSTHRU && retire);

    check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
    check("busy", 32'(busy), 32'(m_full));
    check("in_ready", 32'(bus.in_ready), 32'(rdy));
    if (m_full) check("out_data", 32'(bus.out_data), 32'(m_data));

    // every handshake seen on a branch must match that branch's next token
    for (int i = 0; i < N; i++) begin
      if (bus.out_valid[i] && bus.out_ready[i]) begin
        if (sb[i].size() == 0) check("branch_extra_fire", 32'(i), 32'hFFFF_FFFF);
        else check("branch_data", 32'(bus.out_data), 32'(sb[i].pop_front()));
      end
    end

    take = bus.in_valid && rdy;
    if (take && (cfg_mask != '0)) begin
      m_full = 1'b1;
      m_data = bus.in_data;
      m_mask = cfg_mask;
      m_got  = '0;
      for (int i = 0; i < N; i++)
        if (cfg_mask[i]) sb[i].push_back(bus.in_data);
    end else if (retire) begin
      m_full = 1'b0;
      m_got  = '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (exp_valid[i] && bus.out_ready[i]) m_got[i] = 1'b1;
    end
  endtask

  // compare process: inputs settle at negedge+1, checked at negedge+3
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (reset) begin
        m_started = 1'b1;
        m_full = 1'b0;
        m_data = '0;
        m_mask = '0;
        m_got  = '0;
        for (int i = 0; i < N; i++) sb[i].delete();
      end else if (m_started) begin
        model_cycle();
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int k, guard, first, span, acc;
    logic [31:0] r;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = '0;
    cfg_mask      = '0;
    reset         = 1'b1;
    repeat (2) tick();
    reset = 1'b0;

    // reset then idle
    for (int c = 0; c < 10; c++) begin
      tick();
      #1;
      check("idle_out_valid", 32'(bus.out_valid), 32'h0);
      check("idle_busy", 32'(busy), 32'h0);
      check("idle_in_ready", 32'(bus.in_ready), 32'h1);
      if (c == 0) check("idle_out_data", 32'(bus.out_data), 32'h0);
    end

    // skewed accept: branch 0 at T+1, branch 2 at T+4
    tick();
    bus.in_valid = 1'b1; bus.in_data = 16'h00A5; cfg_mask = 7'b0000101;
    tick();
    bus.in_valid = 1'b0; cfg_mask = 7'h00; bus.out_ready = 7'b0000001;
    #1;
    check("skew_t1_valid", 32'(bus.out_valid), 32'h05);
    check("skew_t1_data", 32'(bus.out_data), 32'h00A5);
    check("skew_t1_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    bus.out_ready = 7'h00;
    #1;
    check("skew_t2_valid", 32'(bus.out_valid), 32'h04);
    tick();
    #1;
    check("skew_t3_busy", 32'(busy), 32'h1);
    check("skew_t3_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    bus.out_ready = 7'b0000100;
    #1;
    check("skew_t4_valid", 32'(bus.out_valid), 32'h04);
    check("skew_t4_busy", 32'(busy), 32'h1);
    check("skew_t4_in_ready", 32'(bus.in_ready), PASSTHRU ? 32'h1 : 32'h0);
    tick();
    bus.out_ready = 7'h00;
    #1;
    check("skew_t5_busy", 32'(busy), 32'h0);
    check("skew_t5_valid", 32'(bus.out_valid), 32'h0);

    // all-ready streaming of tokens 1..8
    cfg_mask = 7'h7F; bus.out_ready = 7'h7F;
    k = 1; guard = 0; first = -1;
    while (k <= 8 && guard < 100) begin
      tick();
      bus.in_valid = 1'b1; bus.in_data = 16'(k);
      #1;
      if (bus.in_ready) begin
        if (first < 0) first = cyc;
        k++;
      end
      guard++;
    end
    check("stream_all_accepted", 32'(k), 32'd9);
    tick();
    bus.in_valid = 1'b0;
    #1;
    guard = 0;
    while (busy && guard < 50) begin
      tick();
      #1;
      guard++;
    end
    check("stream_drain_timeout", 32'(busy), 32'h0);
    // span from first accept cycle to final retire cycle, inclusive
    span = (cyc - 1) - first + 1;
    check("stream_span", 32'(span), PASSTHRU ? 32'd9 : 32'd16);

    // mask change during HOLD
    bus.out_ready = 7'h00;
    tick();
    bus.in_valid = 1'b1; bus.in_data = 16'h1111; cfg_mask = 7'h03;
    tick();
    bus.in_data = 16'h2222; cfg_mask = 7'h40;
    #1;
    check("mchg_hold_valid", 32'(bus.out_valid), 32'h03);
    check("mchg_hold_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    bus.out_ready = 7'h7F;
    #1;
    check("mchg_fire_valid", 32'(bus.out_valid), 32'h03);
    check("mchg_fire_in_ready", 32'(bus.in_ready), PASSTHRU ? 32'h1 : 32'h0);
    acc = int'(bus.in_ready);
    tick();
    if (acc != 0) bus.in_valid = 1'b0;
    #1;
    if (acc != 0) begin
      check("mchg_next_valid", 32'(bus.out_valid), 32'h40);
    end else begin
      check("mchg_gap_valid", 32'(bus.out_valid), 32'h0);
      check("mchg_gap_in_ready", 32'(bus.in_ready), 32'h1);
      tick();
      bus.in_valid = 1'b0;
      #1;
      check("mchg_next_valid", 32'(bus.out_valid), 32'h40);
    end
    tick();
    bus.out_ready = 7'h00; cfg_mask = 7'h00;

    // zero mask: accepted and dropped
    for (int c = 0; c < 3; c++) begin
      tick();
      bus.in_valid = 1'b1; bus.in_data = 16'(16'h0E00 + c); cfg_mask = 7'h00;
      #1;
      check("zero_in_ready", 32'(bus.in_ready), 32'h1);
      check("zero_out_valid", 32'(bus.out_valid), 32'h0);
      check("zero_busy", 32'(busy), 32'h0);
    end
    tick();
    bus.in_valid = 1'b0;
    #1;
    check("zero_after_busy", 32'(busy), 32'h0);
    check("zero_after_valid", 32'(bus.out_valid), 32'h0);

    // reset during HOLD with branch 1 still pending
    tick();
    bus.in_valid = 1'b1; bus.in_data = 16'h3333; cfg_mask = 7'h03;
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 7'h01;
    #1;
    check("rst_hold_valid", 32'(bus.out_valid), 32'h03);
    tick();
    bus.out_ready = 7'h00;
    #1;
    check("rst_pending_valid", 32'(bus.out_valid), 32'h02);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst_after_valid", 32'(bus.out_valid), 32'h0);
    check("rst_after_busy", 32'(busy), 32'h0);
    bus.out_ready = 7'h7F;
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      check("rst_no_replay", 32'(bus.out_valid), 32'h0);
    end

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      tick();
      r = $urandom;
      reset = (r[7:0] < 8'd3);
      r = $urandom;
      bus.in_valid = reset ? 1'b0 : r[0];
      bus.in_data  = r[31:16];
      case (r[3:1])
        3'd0:    cfg_mask = 7'h00;
        3'd1:    cfg_mask = 7'h7F;
        default: cfg_mask = r[14:8];
      endcase
      r = $urandom;
      bus.out_ready = reset ? 7'h00 : (r[0] ? 7'h7F : r[7:1]);
    end

    // drain: every delivered-token queue must empty out
    tick();
    reset = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 7'h7F; cfg_mask = 7'h00;
    repeat (4) tick();
    #3;
    for (int i = 0; i < N; i++) check("drain_queue_empty", 32'(sb[i].size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // run-time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
